strobe_fifo: RTL

//   Sits directly downstream of the clock-crossing strobe stage, in its output clock domain.

---
 rtl/strobe_fifo.sv | 83 ++++++++
 1 files changed

// File: rtl/strobe_fifo.sv
// Strobe-capture FIFO: each strobe_in pulse pushes data_in; head word is presented first-word-fall-through one cycle later.
// No push backpressure; a push while full sets the sticky overflow flag (drop-newest, or drop-oldest with STROBE_FIFO_DROP_OLDEST_EN).
module strobe_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  strobe_in,
  input  logic [WIDTH-1:0]      data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  overflow_q;

  logic full;
  logic pop;
  logic push_acc;
  logic ovf_evt;
  logic wr_en;
  logic rd_adv;

  assign full     = (level_q == FULL_LEVEL);
  assign pop      = out_valid & out_ready;
  assign push_acc = strobe_in & (~full | pop);
  assign ovf_evt  = strobe_in & full & ~pop;

`ifdef STROBE_FIFO_DROP_OLDEST_EN
  // Overwrite the oldest slot and slide the read pointer so the newest DEPTH words survive.
  assign wr_en  = push_acc | ovf_evt;
  assign rd_adv = pop | ovf_evt;
`else
  assign wr_en  = push_acc;
  assign rd_adv = pop;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_adv)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (push_acc && !pop)
        level_q <= level_q + LVL_ONE;
      else if (pop && !push_acc)
        level_q <= level_q - LVL_ONE;
      if (ovf_evt)
        overflow_q <= 1'b1;
      else if (clear_overflow)
        overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && wr_en)
      mem[wr_ptr] <= data_in;
  end

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule
